mem_sram_ctrl: RTL and testbench
================================

# mem_sram_ctrl

Memory-stage data-memory controller: the producer side of the writeback interface. It turns the pipeline's MEM-stage read/write requests into two 16-bit accesses to an external asynchronous SRAM. It returns the assembled 32-bit word as `memData` for the WB stage's result mux, and drives `ready` low while an access is in flight so the hazard/freeze logic stalls every pipeline register.

## Interface
Parameters:
- `WORD_LEN`, 32: pipeline data width; must equal 2 × `SRAM_DW`.
- `SRAM_DW`, 16: SRAM data bus width.
- `SRAM_AW`, 18: SRAM address width.
- `WAIT_CYCLES`, 2: cycles per SRAM half-access; legal range 1–15.
- `DATA_MEM_BASE`, 1024: byte address mapped to SRAM word 0.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `MEM_R_EN` in 1: load request from the EXE/MEM register.
- `MEM_W_EN` in 1: store request from the EXE/MEM register.
- `address` in `WORD_LEN`: byte address (ALU result).
- `writeData` in `WORD_LEN`: store data.
- `memData` out `WORD_LEN`: load result, forwarded to MEM/WB.
- `ready` out 1: 1 means the MEM stage may advance; 0 freezes the pipeline.
- `SRAM_ADDR` out `SRAM_AW`: SRAM address.
- `SRAM_DQ_O` out `SRAM_DW`: write data to the pad.
- `SRAM_DQ_I` in `SRAM_DW`: read data from the pad.
- `SRAM_DQ_OE` out 1: pad output enable.
- `SRAM_WE_N` out 1: SRAM write strobe, active low.

## Operation
- **Address map**
  - `word = (address - DATA_MEM_BASE) >> 2`.
  - Low half goes to `SRAM_ADDR = {word[SRAM_AW-2:0], 1'b0}`.
  - High half goes to `{word[SRAM_AW-2:0], 1'b1}`.
  - `address[1:0]` is ignored; unaligned access is unsupported.
- **FSM states:** IDLE, LO, HI, DONE.
- **IDLE**
  - `ready = ~(MEM_R_EN | MEM_W_EN)`, combinational, so the freeze takes effect in the request cycle.
  - On a request, latch `address`, `writeData`, and the op into internal registers, then go to LO.
  - Write wins if both enables are high; that combination is illegal upstream.
- **LO and HI**
  - Each phase lasts exactly `WAIT_CYCLES` cycles, counted by the phase timer.
  - `SRAM_ADDR` comes from the latched address and is stable for the whole phase.
  - Write op:
    - `SRAM_DQ_OE = 1`.
    - `SRAM_DQ_O` is the latched low half in LO and the high half in HI.
    - `SRAM_WE_N = 0` on every phase cycle except the last, which gives address/data hold before the address changes.
  - Read op:
    - `SRAM_DQ_OE = 0` and `SRAM_WE_N = 1`.
    - `SRAM_DQ_I` is captured into `memData[15:0]` (LO) or `memData[31:16]` (HI) on the last cycle of the phase.
  - LO→HI and HI→DONE transitions happen when the timer expires.
- **DONE**
  - `ready = 1`. `memData` is valid and held.
  - Always goes to IDLE next, even though the enables are still high from the same instruction, because the pipeline advances on this edge.
- **`memData`** is registered. It holds its last value until overwritten by a subsequent read; writes do not change it.
- **Outside write phases**, `SRAM_WE_N = 1` and `SRAM_DQ_OE = 0`.
- **Reset**
  - FSM returns to IDLE and the timer clears.
  - `memData = 0`, `SRAM_WE_N = 1`, `SRAM_DQ_OE = 0`, `SRAM_ADDR = 0`, `SRAM_DQ_O = 0`.
  - `ready = 1` while `rst` is high, independent of the enables.
  - Reset mid-access aborts the access. A partially written word is acceptable; no retry.
- **Request inputs** are sampled only in IDLE; changes during LO/HI/DONE are ignored.

## Timing
- Request seen in IDLE at cycle 0:
  - LO occupies cycles 1..W and HI occupies cycles W+1..2W, where W = `WAIT_CYCLES`.
  - DONE is at cycle 2W+1.
  - `ready` is low for cycles 0..2W (2W+1 cycles) and high at 2W+1.
- W=2 gives 5 stall cycles per memory instruction.
- Back-to-back memory instructions: DONE → IDLE → new request gives one cycle with `ready` low in IDLE. There is no bubble-free chaining.
- Non-memory instructions in IDLE: `ready = 1` every cycle, zero added latency.

## Structure
- Shared defines (alongside `WORD_LEN` in `defines.v`):
  - FSM state encoding.
  - `DATA_MEM_BASE`, `SRAM_DW`, `SRAM_AW`, `WAIT_CYCLES` default.
- One sub-module, `sram_phase_timer`:
  - Loadable 4-bit down-counter; `start` loads `WAIT_CYCLES-1`.
  - Outputs `last` when the count is 0.
  - Used by both LO and HI.
- Top module holds the FSM, latch registers, `memData` halves and pad-drive muxing.

## Test plan
- **Reset:** `rst=1` for 2 cycles with `MEM_R_EN=1` -> `ready=1`, `memData=0`, `SRAM_WE_N=1`, `SRAM_DQ_OE=0`; after release, the FSM enters LO the cycle after the request.
- **Read, W=2:** `address=1028`, SRAM model word2=`16'hBEEF`, word3=`16'hDEAD` -> `SRAM_ADDR` is 2 for cycles 1–2 and 3 for cycles 3–4; `ready` is low for cycles 0–4; `memData=32'hDEADBEEF` with `ready=1` at cycle 5.
- **Write:** `address=1024`, `writeData=32'h12345678` -> SRAM word0=`16'h5678`, word1=`16'h1234`; `SRAM_WE_N` low only on cycles 1 and 3; `memData` unchanged.
- **Back-to-back:** store then load to the same address -> the load returns the stored word; `ready` stays low for exactly one cycle in IDLE between the accesses.
- **Simultaneous enables and mid-op input changes:** `MEM_R_EN=MEM_W_EN=1` -> a write is performed; toggling `address` during HI does not alter `SRAM_ADDR`.
- **Reset mid-access:** `rst` asserted at cycle 3 of a read -> next cycle is IDLE, `ready=1`, `memData=0`, and the SRAM strobes are inactive.

Source files
------------

// File: rtl/mem_sram_ctrl_pkg.sv
// Shared constants and FSM encoding for the MEM-stage SRAM controller.
// The controller splits each 32-bit access into two 16-bit SRAM half-accesses.
package mem_sram_ctrl_pkg;

  localparam int DEF_WORD_LEN      = 32;
  localparam int DEF_SRAM_DW       = 16;
  localparam int DEF_SRAM_AW       = 18;
  localparam int DEF_WAIT_CYCLES   = 2;
  localparam int DEF_DATA_MEM_BASE = 1024;
  localparam int TIMER_W           = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LO,
    ST_HI,
    ST_DONE
  } state_e;

endpackage

// File: rtl/sram_phase_timer.sv
// Loadable down-counter that times one SRAM half-access.
// The last_o flag marks the final cycle of the phase.
module sram_phase_timer
  import mem_sram_ctrl_pkg::*;
#(
  parameter logic [TIMER_W-1:0] LOAD_VAL = TIMER_W'(1)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  output logic last_o
);

  logic [TIMER_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (start_i) begin
      count_d = LOAD_VAL;
    end else if (count_q != '0) begin
      count_d = count_q - TIMER_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last_o = (count_q == '0);

endmodule

// File: rtl/mem_sram_ctrl.sv
// MEM-stage data-memory controller: turns a 32-bit load/store into two
// timed 16-bit SRAM accesses and freezes the pipeline while it runs.
module mem_sram_ctrl
  import mem_sram_ctrl_pkg::*;
#(
  parameter int WORD_LEN      = DEF_WORD_LEN,
  parameter int SRAM_DW       = DEF_SRAM_DW,
  parameter int SRAM_AW       = DEF_SRAM_AW,
  parameter int WAIT_CYCLES   = DEF_WAIT_CYCLES,
  parameter int DATA_MEM_BASE = DEF_DATA_MEM_BASE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                MEM_R_EN,
  input  logic                MEM_W_EN,
  input  logic [WORD_LEN-1:0] address,
  input  logic [WORD_LEN-1:0] writeData,
  output logic [WORD_LEN-1:0] memData,
  output logic                ready,
  output logic [SRAM_AW-1:0]  SRAM_ADDR,
  output logic [SRAM_DW-1:0]  SRAM_DQ_O,
  input  logic [SRAM_DW-1:0]  SRAM_DQ_I,
  output logic                SRAM_DQ_OE,
  output logic                SRAM_WE_N
);

  localparam int                 WORD_AW    = SRAM_AW - 1;
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(WAIT_CYCLES - 1);

  state_e              state_q, state_d;
  logic [WORD_AW-1:0]  word_q, word_d;
  logic [WORD_LEN-1:0] wdata_q, wdata_d;
  logic                isWrite_q, isWrite_d;
  logic [SRAM_DW-1:0]  memLo_q, memLo_d;
  logic [SRAM_DW-1:0]  memHi_q, memHi_d;

  logic                request;
  logic                timerStart;
  logic                timerLast;
  logic                inPhase;
  logic                hiPhase;
  logic                driveWrite;
  logic [WORD_LEN-1:0] offset;
  logic                unusedOffsetBits;

  assign request = MEM_R_EN | MEM_W_EN;
  assign offset  = address - WORD_LEN'(DATA_MEM_BASE);
  // Byte-offset bits and bits beyond the SRAM range do not reach the pads.
  assign unusedOffsetBits = ^{offset[WORD_LEN-1:SRAM_AW+1], offset[1:0]};

  sram_phase_timer #(
    .LOAD_VAL(TIMER_LOAD)
  ) u_timer (
    .clk_i  (clk),
    .rst_i  (rst),
    .start_i(timerStart),
    .last_o (timerLast)
  );

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    wdata_d    = wdata_q;
    isWrite_d  = isWrite_q;
    memLo_d    = memLo_q;
    memHi_d    = memHi_q;
    timerStart = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (request) begin
          word_d     = offset[SRAM_AW:2];
          wdata_d    = writeData;
          isWrite_d  = MEM_W_EN;
          timerStart = 1'b1;
          state_d    = ST_LO;
        end
      end
      ST_LO: begin
        if (timerLast) begin
          if (!isWrite_q) memLo_d = SRAM_DQ_I;
          timerStart = 1'b1;
          state_d    = ST_HI;
        end
      end
      ST_HI: begin
        if (timerLast) begin
          if (!isWrite_q) memHi_d = SRAM_DQ_I;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      word_q    <= '0;
      wdata_q   <= '0;
      isWrite_q <= 1'b0;
      memLo_q   <= '0;
      memHi_q   <= '0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      wdata_q   <= wdata_d;
      isWrite_q <= isWrite_d;
      memLo_q   <= memLo_d;
      memHi_q   <= memHi_d;
    end
  end

  // Pads stay quiet while reset is held, even before the state register clears.
  assign inPhase    = ((state_q == ST_LO) || (state_q == ST_HI)) && !rst;
  assign hiPhase    = (state_q == ST_HI);
  assign driveWrite = inPhase && isWrite_q;

  always_comb begin
    ready      = 1'b0;
    SRAM_ADDR  = '0;
    SRAM_DQ_O  = '0;
    SRAM_DQ_OE = 1'b0;
    SRAM_WE_N  = 1'b1;
    if (rst) begin
      ready = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: ready = ~request;
        ST_DONE: ready = 1'b1;
        default: ready = 1'b0;
      endcase
    end
    if (inPhase) begin
      SRAM_ADDR = {word_q, hiPhase};
    end
    if (driveWrite) begin
      SRAM_DQ_OE = 1'b1;
      SRAM_DQ_O  = hiPhase ? wdata_q[WORD_LEN-1:SRAM_DW] : wdata_q[SRAM_DW-1:0];
      // Strobe released on the final phase cycle for address/data hold.
      SRAM_WE_N  = timerLast;
    end
  end

  assign memData = {memHi_q, memLo_q};

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Directed bench for mem_sram_ctrl with a small 16-entry SRAM model;
// each task drives one scenario and checks hand-computed values inline.
module tb_mem_sram_ctrl;

  logic        clk;
  logic        rst;
  logic        MEM_R_EN;
  logic        MEM_W_EN;
  logic [31:0] address;
  logic [31:0] writeData;
  logic [31:0] memData;
  logic        ready;
  logic [17:0] SRAM_ADDR;
  logic [15:0] SRAM_DQ_O;
  logic [15:0] SRAM_DQ_I;
  logic        SRAM_DQ_OE;
  logic        SRAM_WE_N;

  logic [15:0] sramMem [0:15];
  logic        preloadEn;
  logic [3:0]  preloadAddr;
  logic [15:0] preloadData;

  int total;
  int bad;

  mem_sram_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .MEM_R_EN  (MEM_R_EN),
    .MEM_W_EN  (MEM_W_EN),
    .address   (address),
    .writeData (writeData),
    .memData   (memData),
    .ready     (ready),
    .SRAM_ADDR (SRAM_ADDR),
    .SRAM_DQ_O (SRAM_DQ_O),
    .SRAM_DQ_I (SRAM_DQ_I),
    .SRAM_DQ_OE(SRAM_DQ_OE),
    .SRAM_WE_N (SRAM_WE_N)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (preloadEn) begin
      sramMem[preloadAddr] <= preloadData;
    end else if (!SRAM_WE_N && SRAM_DQ_OE) begin
      sramMem[SRAM_ADDR[3:0]] <= SRAM_DQ_O;
    end
  end

  assign SRAM_DQ_I = sramMem[SRAM_ADDR[3:0]];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [3:0] a, input logic [15:0] d);
    preloadEn   = 1'b1;
    preloadAddr = a;
    preloadData = d;
    tick();
    preloadEn = 1'b0;
  endtask

  task automatic test_reset();
    preload(4'd2, 16'hBEEF);
    preload(4'd3, 16'hDEAD);
    preload(4'd4, 16'h1111);
    preload(4'd5, 16'h2222);
    MEM_R_EN = 1'b1;
    address  = 32'd1032;
    tick();
    tick();
    total++; if (ready !== 1'b1) begin $display("FAIL rst_ready got=%b want=1", ready); bad++; end
    total++; if (memData !== 32'h0) begin $display("FAIL rst_memData got=%h want=0", memData); bad++; end
    total++; if (SRAM_WE_N !== 1'b1) begin $display("FAIL rst_we_n got=%b want=1", SRAM_WE_N); bad++; end
    total++; if (SRAM_DQ_OE !== 1'b0) begin $display("FAIL rst_oe got=%b want=0", SRAM_DQ_OE); bad++; end
    total++; if (SRAM_ADDR !== 18'd0) begin $display("FAIL rst_addr got=%0d want=0", SRAM_ADDR); bad++; end
    rst = 1'b0;
    #1;
    total++; if (ready !== 1'b0) begin $display("FAIL rst_release_ready got=%b want=0", ready); bad++; end
    tick();
    total++; if (SRAM_ADDR !== 18'd4) begin $display("FAIL rst_enter_lo_addr got=%0d want=4", SRAM_ADDR); bad++; end
    total++; if (ready !== 1'b0) begin $display("FAIL rst_enter_lo_ready got=%b want=0", ready); bad++; end
    repeat (4) tick();
    total++; if (memData !== 32'h22221111) begin $display("FAIL rst_read_data got=%h want=22221111", memData); bad++; end
    MEM_R_EN = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      total++; if (ready !== 1'b1) begin $display("FAIL idle_nonmem_ready cyc=%0d got=%b want=1", c, ready); bad++; end
    end
  endtask

  task automatic test_read();
    MEM_R_EN = 1'b1;
    address  = 32'd1028;
    #1;
    total++; if (ready !== 1'b0) begin $display("FAIL read_c0_ready got=%b want=0", ready); bad++; end
    for (int c = 1; c <= 4; c++) begin
      tick();
      total++; if (SRAM_ADDR !== ((c <= 2) ? 18'd2 : 18'd3)) begin $display("FAIL read_addr cyc=%0d got=%0d", c, SRAM_ADDR); bad++; end
      total++; if (ready !== 1'b0) begin $display("FAIL read_ready cyc=%0d got=%b want=0", c, ready); bad++; end
      total++; if ({SRAM_DQ_OE, SRAM_WE_N} !== 2'b01) begin $display("FAIL read_strobes cyc=%0d got=%b want=01", c, {SRAM_DQ_OE, SRAM_WE_N}); bad++; end
    end
    tick();
    total++; if (ready !== 1'b1) begin $display("FAIL read_done_ready got=%b want=1", ready); bad++; end
    total++; if (memData !== 32'hDEADBEEF) begin $display("FAIL read_data got=%h want=deadbeef", memData); bad++; end
    MEM_R_EN = 1'b0;
    tick();
  endtask

  task automatic test_write();
    MEM_W_EN  = 1'b1;
    address   = 32'd1024;
    writeData = 32'h12345678;
    #1;
    total++; if ({ready, SRAM_WE_N} !== 2'b01) begin $display("FAIL write_c0 got=%b want=01", {ready, SRAM_WE_N}); bad++; end
    for (int c = 1; c <= 4; c++) begin
      tick();
      total++; if (SRAM_WE_N !== ((c % 2 == 1) ? 1'b0 : 1'b1)) begin $display("FAIL write_we_n cyc=%0d got=%b", c, SRAM_WE_N); bad++; end
      total++; if (SRAM_DQ_O !== ((c <= 2) ? 16'h5678 : 16'h1234)) begin $display("FAIL write_dq cyc=%0d got=%h", c, SRAM_DQ_O); bad++; end
      total++; if (SRAM_ADDR !== ((c <= 2) ? 18'd0 : 18'd1)) begin $display("FAIL write_addr cyc=%0d got=%0d", c, SRAM_ADDR); bad++; end
      total++; if (SRAM_DQ_OE !== 1'b1) begin $display("FAIL write_oe cyc=%0d got=%b want=1", c, SRAM_DQ_OE); bad++; end
    end
    tick();
    total++; if (ready !== 1'b1) begin $display("FAIL write_done_ready got=%b want=1", ready); bad++; end
    total++; if (memData !== 32'hDEADBEEF) begin $display("FAIL write_memData_held got=%h want=deadbeef", memData); bad++; end
    MEM_W_EN = 1'b0;
    tick();
    total++; if (sramMem[0] !== 16'h5678) begin $display("FAIL write_word0 got=%h want=5678", sramMem[0]); bad++; end
    total++; if (sramMem[1] !== 16'h1234) begin $display("FAIL write_word1 got=%h want=1234", sramMem[1]); bad++; end
  endtask

  task automatic test_back_to_back();
    MEM_W_EN  = 1'b1;
    address   = 32'd1040;
    writeData = 32'hCAFEF00D;
    repeat (5) tick();
    total++; if (ready !== 1'b1) begin $display("FAIL b2b_store_done got=%b want=1", ready); bad++; end
    MEM_W_EN = 1'b0;
    MEM_R_EN = 1'b1;
    tick();
    total++; if (ready !== 1'b0) begin $display("FAIL b2b_idle_bubble got=%b want=0", ready); bad++; end
    for (int c = 1; c <= 4; c++) begin
      tick();
      total++; if (ready !== 1'b0) begin $display("FAIL b2b_load_ready cyc=%0d got=%b want=0", c, ready); bad++; end
    end
    tick();
    total++; if (ready !== 1'b1) begin $display("FAIL b2b_load_done got=%b want=1", ready); bad++; end
    total++; if (memData !== 32'hCAFEF00D) begin $display("FAIL b2b_load_data got=%h want=cafef00d", memData); bad++; end
    MEM_R_EN = 1'b0;
    tick();
    total++; if (ready !== 1'b1) begin $display("FAIL b2b_after got=%b want=1", ready); bad++; end
  endtask

  task automatic test_simultaneous();
    MEM_R_EN  = 1'b1;
    MEM_W_EN  = 1'b1;
    address   = 32'd1048;
    writeData = 32'hA5A55A5A;
    tick();
    tick();
    tick();
    address  = 32'd1024;
    MEM_R_EN = 1'b0;
    MEM_W_EN = 1'b0;
    #1;
    total++; if (SRAM_ADDR !== 18'd13) begin $display("FAIL simul_addr_c3 got=%0d want=13", SRAM_ADDR); bad++; end
    total++; if (SRAM_WE_N !== 1'b0) begin $display("FAIL simul_we_n_c3 got=%b want=0", SRAM_WE_N); bad++; end
    total++; if (SRAM_DQ_O !== 16'hA5A5) begin $display("FAIL simul_dq_c3 got=%h want=a5a5", SRAM_DQ_O); bad++; end
    total++; if (ready !== 1'b0) begin $display("FAIL simul_ready_c3 got=%b want=0", ready); bad++; end
    tick();
    total++; if (SRAM_ADDR !== 18'd13) begin $display("FAIL simul_addr_c4 got=%0d want=13", SRAM_ADDR); bad++; end
    tick();
    total++; if (ready !== 1'b1) begin $display("FAIL simul_done got=%b want=1", ready); bad++; end
    total++; if (memData !== 32'hCAFEF00D) begin $display("FAIL simul_memData_held got=%h want=cafef00d", memData); bad++; end
    tick();
    total++; if (sramMem[12] !== 16'h5A5A) begin $display("FAIL simul_word12 got=%h want=5a5a", sramMem[12]); bad++; end
    total++; if (sramMem[13] !== 16'hA5A5) begin $display("FAIL simul_word13 got=%h want=a5a5", sramMem[13]); bad++; end
  endtask

  task automatic test_reset_mid();
    MEM_R_EN = 1'b1;
    address  = 32'd1028;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    total++; if (ready !== 1'b1) begin $display("FAIL mid_rst_ready got=%b want=1", ready); bad++; end
    tick();
    rst      = 1'b0;
    MEM_R_EN = 1'b0;
    #1;
    total++; if (ready !== 1'b1) begin $display("FAIL mid_after_ready got=%b want=1", ready); bad++; end
    total++; if (memData !== 32'h0) begin $display("FAIL mid_after_memData got=%h want=0", memData); bad++; end
    total++; if ({SRAM_DQ_OE, SRAM_WE_N} !== 2'b01) begin $display("FAIL mid_after_strobes got=%b want=01", {SRAM_DQ_OE, SRAM_WE_N}); bad++; end
    total++; if (SRAM_ADDR !== 18'd0) begin $display("FAIL mid_after_addr got=%0d want=0", SRAM_ADDR); bad++; end
    tick();
    total++; if (ready !== 1'b1) begin $display("FAIL mid_idle_ready got=%b want=1", ready); bad++; end
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    rst         = 1'b1;
    MEM_R_EN    = 1'b0;
    MEM_W_EN    = 1'b0;
    address     = 32'd0;
    writeData   = 32'd0;
    preloadEn   = 1'b0;
    preloadAddr = 4'd0;
    preloadData = 16'd0;
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_simultaneous();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] timeout");
  end

endmodule
